// File: rtl/pll_rst_pkg.sv
// Shared types and defaults for the PLL lock qualifier / reset sequencer.
// Optional feature macro: PLL_LOCK_LOSS_COUNT_EN (lock-loss event counter).
package pll_rst_pkg;

  typedef enum logic [1:0] {
    StWaitLock = 2'd0,
    StHold     = 2'd1,
    StRelease  = 2'd2,
    StRun      = 2'd3
  } pll_rst_state_e;

  // Defaults for a 60 MHz PLL output clock.
  localparam int unsigned DefaultStableCycles = 600;  // 10 us
  localparam int unsigned DefaultHoldCycles   = 16;

  localparam int unsigned LossCountW = 8;

  // Saturating increment for the lock-loss counter.
  function automatic logic [LossCountW-1:0] sat_inc(input logic [LossCountW-1:0] v);
    return (v == {LossCountW{1'b1}}) ? v : v + LossCountW'(1);
  endfunction

endpackage

// File: rtl/sync_ff.sv
// N-stage single-bit synchroniser with synchronous active-high clear.
module sync_ff #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q, sync_d;

  // Shift the asynchronous input through the flop chain.
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d_i};
  end

  // Chain registers, cleared by the block reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pll_lock_reset_seq.sv
// PLL lock qualifier and staggered reset release sequencer.
// Synchronises locked_in, requires it stable for STABLE_CYCLES, holds resets for
// HOLD_CYCLES, then releases reset_out[0..N_OUT-1] STAGGER_CYCLES apart.
// Optional feature macro: PLL_LOCK_LOSS_COUNT_EN adds the lock_loss_count output.
module pll_lock_reset_seq
  import pll_rst_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned STABLE_CYCLES  = DefaultStableCycles,
  parameter int unsigned HOLD_CYCLES    = DefaultHoldCycles,
  parameter int unsigned N_OUT          = 2,
  parameter int unsigned STAGGER_CYCLES = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             locked_in,
  output logic [N_OUT-1:0] reset_out,
  output logic             ready,
  output logic             lock_lost
`ifdef PLL_LOCK_LOSS_COUNT_EN
  ,
  output logic [LossCountW-1:0] lock_loss_count
`endif
);

  localparam int unsigned StableW  = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned HoldW    = $clog2(HOLD_CYCLES + 1);
  localparam int unsigned StaggerW = $clog2(STAGGER_CYCLES + 1);

  localparam logic [StableW-1:0]  StableMax  = StableW'(STABLE_CYCLES - 1);
  localparam logic [HoldW-1:0]    HoldMax    = HoldW'(HOLD_CYCLES - 1);
  localparam logic [StaggerW-1:0] StaggerMax = StaggerW'(STAGGER_CYCLES - 1);

  logic locked_s;

  sync_ff #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk_i(clock),
    .rst_i(reset),
    .d_i  (locked_in),
    .q_o  (locked_s)
  );

  pll_rst_state_e      state_q, state_d;
  logic [StableW-1:0]  stable_cnt_q, stable_cnt_d;
  logic [HoldW-1:0]    hold_cnt_q, hold_cnt_d;
  logic [StaggerW-1:0] stag_cnt_q, stag_cnt_d;
  logic [N_OUT-1:0]    reset_out_q, reset_out_d;
  logic                ready_q, ready_d;
  logic                lock_lost_q, lock_lost_d;

  // Next-state: counters default to zero so each one is cleared on state entry.
  always_comb begin
    state_d      = state_q;
    stable_cnt_d = '0;
    hold_cnt_d   = '0;
    stag_cnt_d   = '0;
    reset_out_d  = reset_out_q;
    ready_d      = 1'b0;
    lock_lost_d  = 1'b0;

    unique case (state_q)
      StWaitLock: begin
        reset_out_d = '1;
        if (locked_s) begin
          if (stable_cnt_q == StableMax) begin
            state_d = StHold;
          end else begin
            stable_cnt_d = stable_cnt_q + StableW'(1);
          end
        end
      end

      StHold: begin
        reset_out_d = '1;
        if (!locked_s) begin
          // Domain never released, so no lock_lost pulse.
          state_d = StWaitLock;
        end else if (hold_cnt_q == HoldMax) begin
          state_d     = StRelease;
          reset_out_d = reset_out_q << 1;  // release bit 0 on entry
        end else begin
          hold_cnt_d = hold_cnt_q + HoldW'(1);
        end
      end

      StRelease: begin
        if (!locked_s) begin
          state_d     = StWaitLock;
          reset_out_d = '1;
          lock_lost_d = 1'b1;
        end else if (reset_out_q == '0) begin
          state_d = StRun;
          ready_d = 1'b1;
        end else if (stag_cnt_q == StaggerMax) begin
          // Released bits are the low-order zeros; shifting releases the next one.
          reset_out_d = reset_out_q << 1;
        end else begin
          stag_cnt_d = stag_cnt_q + StaggerW'(1);
        end
      end

      StRun: begin
        if (!locked_s) begin
          state_d     = StWaitLock;
          reset_out_d = '1;
          lock_lost_d = 1'b1;
        end else begin
          reset_out_d = '0;
          ready_d     = 1'b1;
        end
      end

      default: begin
        state_d     = StWaitLock;
        reset_out_d = '1;
      end
    endcase
  end

  // State, counters and registered outputs; reset overrides everything.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= StWaitLock;
      stable_cnt_q <= '0;
      hold_cnt_q   <= '0;
      stag_cnt_q   <= '0;
      reset_out_q  <= '1;
      ready_q      <= 1'b0;
      lock_lost_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      stable_cnt_q <= stable_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
      stag_cnt_q   <= stag_cnt_d;
      reset_out_q  <= reset_out_d;
      ready_q      <= ready_d;
      lock_lost_q  <= lock_lost_d;
    end
  end

  assign reset_out = reset_out_q;
  assign ready     = ready_q;
  assign lock_lost = lock_lost_q;

`ifdef PLL_LOCK_LOSS_COUNT_EN
  logic [LossCountW-1:0] loss_cnt_q, loss_cnt_d;

  // Count lock_lost pulses, saturating; survives re-lock.
  always_comb begin
    loss_cnt_d = lock_lost_d ? sat_inc(loss_cnt_q) : loss_cnt_q;
  end

  // Loss counter register, cleared only by reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      loss_cnt_q <= '0;
    end else begin
      loss_cnt_q <= loss_cnt_d;
    end
  end

  assign lock_loss_count = loss_cnt_q;
`endif

endmodule
